// File: rtl/mem_arb.sv
// Shared memory port arbiter: serialises Z80 and LCD video fetches onto one
// SRAM/ROM bus, Z80 first, with in-flight video accesses never pre-empted.
module mem_arb #(
    parameter int ACC_CYC = 2
) (
    input  logic        mck,
    input  logic        rst,
    input  logic        z_req,
    input  logic        z_wr,
    input  logic [21:0] z_addr,
    input  logic [7:0]  z_wdata,
    output logic [7:0]  z_rdata,
    output logic        z_wait_n,
    input  logic        v_req,
    input  logic [21:0] v_addr,
    output logic        v_ack,
    output logic        v_valid,
    output logic [7:0]  v_rdata,
    output logic [21:0] mem_addr,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [7:0]  mem_dout,
    output logic        mem_dq_oe,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {IDLE, Z_ACC, V_ACC} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        z_req_prev_q, z_req_prev_d;
    logic        pend_q, pend_d;
    logic        lat_wr_q, lat_wr_d;
    logic [21:0] lat_addr_q, lat_addr_d;
    logic [7:0]  lat_wdata_q, lat_wdata_d;
    logic [21:0] mem_addr_q, mem_addr_d;
    logic        mem_ce_n_q, mem_ce_n_d;
    logic        mem_oe_n_q, mem_oe_n_d;
    logic        mem_we_n_q, mem_we_n_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_dq_oe_q, mem_dq_oe_d;
    logic [7:0]  z_rdata_q, z_rdata_d;
    logic        z_wait_n_q, z_wait_n_d;
    logic        v_ack_q, v_ack_d;
    logic        v_valid_q, v_valid_d;
    logic [7:0]  v_rdata_q, v_rdata_d;

    logic        z_new, last_cyc, decide, z_go, v_go, start_z, start_v;
    logic        acc_wr;
    logic [21:0] acc_addr;
    logic [7:0]  acc_wdata;

    always_comb begin
        z_new    = z_req & ~z_req_prev_q;
        last_cyc = (state_q != IDLE) && (cnt_q == 3'd0);
        decide   = (state_q == IDLE) || last_cyc;
        z_go     = z_new | (pend_q & z_req);
        // v_req is still high in the ack cycle; it belongs to the access already taken.
        v_go     = v_req & ~v_ack_q;
        start_z  = decide & z_go;
        start_v  = decide & ~z_go & v_go;

        // A fresh request goes straight onto the bus before its latch is loaded.
        acc_wr    = z_new ? z_wr    : lat_wr_q;
        acc_addr  = z_new ? z_addr  : lat_addr_q;
        acc_wdata = z_new ? z_wdata : lat_wdata_q;

        z_req_prev_d = z_req;
        lat_wr_d     = lat_wr_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        if (z_new) begin
            lat_wr_d    = z_wr;
            lat_addr_d  = z_addr;
            lat_wdata_d = z_wdata;
        end

        pend_d = pend_q;
        if (z_new)
            pend_d = 1'b1;
        if (pend_q && !z_req)
            pend_d = 1'b0;
        if (start_z)
            pend_d = 1'b0;

        state_d = state_q;
        cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (decide) begin
            if (start_z)
                state_d = Z_ACC;
            else if (start_v)
                state_d = V_ACC;
            else
                state_d = IDLE;
        end
        if (start_z || start_v)
            cnt_d = 3'(ACC_CYC - 1);

        mem_addr_d  = mem_addr_q;
        mem_ce_n_d  = mem_ce_n_q;
        mem_oe_n_d  = mem_oe_n_q;
        mem_we_n_d  = mem_we_n_q;
        mem_dout_d  = mem_dout_q;
        mem_dq_oe_d = mem_dq_oe_q;
        if (decide) begin
            mem_ce_n_d  = 1'b1;
            mem_oe_n_d  = 1'b1;
            mem_we_n_d  = 1'b1;
            mem_dq_oe_d = 1'b0;
            if (start_z) begin
                mem_addr_d = acc_addr;
                mem_ce_n_d = 1'b0;
                if (acc_wr) begin
                    mem_we_n_d  = 1'b0;
                    mem_dq_oe_d = 1'b1;
                    mem_dout_d  = acc_wdata;
                end else begin
                    mem_oe_n_d = 1'b0;
                end
            end else if (start_v) begin
                mem_addr_d = v_addr;
                mem_ce_n_d = 1'b0;
                mem_oe_n_d = 1'b0;
            end
        end

        v_ack_d    = start_v;
        v_valid_d  = last_cyc && (state_q == V_ACC);
        v_rdata_d  = v_valid_d ? mem_din : v_rdata_q;
        // The registered write strobe tells a Z80 read from a write on the final edge.
        z_rdata_d  = (last_cyc && (state_q == Z_ACC) && mem_we_n_q) ? mem_din : z_rdata_q;
        z_wait_n_d = ~pend_d;
    end

    always_ff @(posedge mck) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            z_req_prev_q <= 1'b0;
            pend_q       <= 1'b0;
            lat_wr_q     <= 1'b0;
            lat_addr_q   <= 22'd0;
            lat_wdata_q  <= 8'd0;
            mem_addr_q   <= 22'd0;
            mem_ce_n_q   <= 1'b1;
            mem_oe_n_q   <= 1'b1;
            mem_we_n_q   <= 1'b1;
            mem_dout_q   <= 8'd0;
            mem_dq_oe_q  <= 1'b0;
            z_rdata_q    <= 8'd0;
            z_wait_n_q   <= 1'b1;
            v_ack_q      <= 1'b0;
            v_valid_q    <= 1'b0;
            v_rdata_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            z_req_prev_q <= z_req_prev_d;
            pend_q       <= pend_d;
            lat_wr_q     <= lat_wr_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_ce_n_q   <= mem_ce_n_d;
            mem_oe_n_q   <= mem_oe_n_d;
            mem_we_n_q   <= mem_we_n_d;
            mem_dout_q   <= mem_dout_d;
            mem_dq_oe_q  <= mem_dq_oe_d;
            z_rdata_q    <= z_rdata_d;
            z_wait_n_q   <= z_wait_n_d;
            v_ack_q      <= v_ack_d;
            v_valid_q    <= v_valid_d;
            v_rdata_q    <= v_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_ce_n  = mem_ce_n_q;
    assign mem_oe_n  = mem_oe_n_q;
    assign mem_we_n  = mem_we_n_q;
    assign mem_dout  = mem_dout_q;
    assign mem_dq_oe = mem_dq_oe_q;
    assign z_rdata   = z_rdata_q;
    assign z_wait_n  = z_wait_n_q;
    assign v_ack     = v_ack_q;
    assign v_valid   = v_valid_q;
    assign v_rdata   = v_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus random Z80/video traffic, all
// checked cycle by cycle against a bus-schedule reference model.
module tb_mem_arb;

    localparam int ACC_CYC = 2;

    logic        mck = 1'b0;
    logic        rst;
    logic        z_req, z_wr;
    logic [21:0] z_addr;
    logic [7:0]  z_wdata, z_rdata;
    logic        z_wait_n;
    logic        v_req;
    logic [21:0] v_addr;
    logic        v_ack, v_valid;
    logic [7:0]  v_rdata;
    logic [21:0] mem_addr;
    logic        mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe;
    logic [7:0]  mem_dout, mem_din;

    mem_arb #(.ACC_CYC(ACC_CYC)) dut (
        .mck(mck), .rst(rst),
        .z_req(z_req), .z_wr(z_wr), .z_addr(z_addr), .z_wdata(z_wdata),
        .z_rdata(z_rdata), .z_wait_n(z_wait_n),
        .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_valid(v_valid),
        .v_rdata(v_rdata),
        .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n), .mem_dout(mem_dout), .mem_dq_oe(mem_dq_oe),
        .mem_din(mem_din)
    );

    always #5 mck = ~mck;

    int check_count = 0;
    int pass_count  = 0;
    int cyc = 0;
    bit acked_last = 1'b0;

    // Reference: the Z80 request as the model sees it, plus the one access
    // occupying the bus over cycles [m_start, m_end] (m_kind 0 none, 1 Z80, 2 video).
    bit          m_zprev, m_pend, m_lwr;
    logic [21:0] m_laddr;
    logic [7:0]  m_ldata;
    int          m_kind, m_start, m_end;
    bit          m_wr;
    logic [21:0] m_addr;
    logic [7:0]  m_data;

    logic        e_ce_n, e_oe_n, e_we_n, e_dq_oe, e_wait_n, e_ack, e_valid;
    logic [21:0] e_addr;
    logic [7:0]  e_dout, e_zrdata, e_vrdata;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // Computes the expected outputs of the next cycle from this cycle's inputs.
    task automatic modelStep();
        bit zn, free_next, acked_now;
        if (rst) begin
            m_zprev = 0; m_pend = 0; m_kind = 0;
            e_ce_n = 1; e_oe_n = 1; e_we_n = 1; e_dq_oe = 0;
            e_addr = '0; e_dout = '0; e_zrdata = '0; e_wait_n = 1;
            e_ack = 0; e_valid = 0; e_vrdata = '0;
            return;
        end
        e_ack = 0;
        e_valid = 0;
        if (m_kind != 0 && m_end == cyc) begin
            if (m_kind == 2) begin
                e_valid  = 1;
                e_vrdata = mem_din;
            end else if (!m_wr) begin
                e_zrdata = mem_din;
            end
        end
        free_next = (m_kind == 0) || (m_end == cyc);
        acked_now = (m_kind == 2) && (m_start == cyc);
        zn = z_req && !m_zprev;
        m_zprev = z_req;
        if (zn) begin
            m_lwr = z_wr; m_laddr = z_addr; m_ldata = z_wdata;
        end
        if (m_pend && !z_req)
            m_pend = 0;
        if (zn)
            m_pend = 1;
        if (free_next) begin
            m_kind = 0;
            if (m_pend) begin
                m_kind = 1; m_wr = m_lwr; m_addr = m_laddr; m_data = m_ldata;
                m_pend = 0;
            end else if (v_req && !acked_now) begin
                m_kind = 2; m_wr = 0; m_addr = v_addr;
                e_ack = 1;
            end
            m_start = cyc + 1;
            m_end   = cyc + ACC_CYC;
        end
        e_ce_n = 1; e_oe_n = 1; e_we_n = 1; e_dq_oe = 0;
        if (m_kind != 0) begin
            e_ce_n = 0;
            e_addr = m_addr;
            if (m_kind == 1 && m_wr) begin
                e_we_n = 0; e_dq_oe = 1; e_dout = m_data;
            end else begin
                e_oe_n = 0;
            end
        end
        e_wait_n = !m_pend;
    endtask

    // Checks the current cycle, applies the video hand-off rule, then advances.
    task automatic stepCycle();
        checkOutput("mem_ce_n",  32'(mem_ce_n),  32'(e_ce_n));
        checkOutput("mem_oe_n",  32'(mem_oe_n),  32'(e_oe_n));
        checkOutput("mem_we_n",  32'(mem_we_n),  32'(e_we_n));
        checkOutput("mem_dq_oe", 32'(mem_dq_oe), 32'(e_dq_oe));
        checkOutput("mem_addr",  32'(mem_addr),  32'(e_addr));
        checkOutput("mem_dout",  32'(mem_dout),  32'(e_dout));
        checkOutput("z_rdata",   32'(z_rdata),   32'(e_zrdata));
        checkOutput("z_wait_n",  32'(z_wait_n),  32'(e_wait_n));
        checkOutput("v_ack",     32'(v_ack),     32'(e_ack));
        checkOutput("v_valid",   32'(v_valid),   32'(e_valid));
        checkOutput("v_rdata",   32'(v_rdata),   32'(e_vrdata));
        if (v_req && acked_last)
            v_req = 1'b0;
        acked_last = e_ack;
        modelStep();
        @(posedge mck);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus();
        rst = ($urandom_range(0, 99) == 0);
        if (z_req)
            z_req = ($urandom_range(0, 3) != 0);
        else
            z_req = ($urandom_range(0, 3) == 0);
        z_wr    = 1'($urandom);
        z_addr  = 22'($urandom);
        z_wdata = 8'($urandom);
        if (!v_req && $urandom_range(0, 2) == 0) begin
            v_req  = 1'b1;
            v_addr = 22'($urandom);
        end
        mem_din = 8'($urandom);
    endtask

    task automatic idle(input int n);
        z_req = 0; v_req = 0; z_wr = 0;
        for (int i = 0; i < n; i++)
            stepCycle();
    endtask

    initial begin
        rst = 1; z_req = 0; z_wr = 0; z_addr = '0; z_wdata = '0;
        v_req = 0; v_addr = '0; mem_din = '0;
        modelStep();
        @(posedge mck);
        #1;
        stepCycle();
        rst = 0;
        idle(2);

        // Isolated Z80 read
        z_req = 1; z_wr = 0; z_addr = 22'h080123; mem_din = 8'h5A;
        stepCycle();
        checkOutput("iso_addr", 32'(mem_addr), 32'h080123);
        stepCycle();
        stepCycle();
        checkOutput("iso_rdata", 32'(z_rdata), 32'h5A);
        idle(2);

        // Z80 write
        z_req = 1; z_wr = 1; z_addr = 22'h200010; z_wdata = 8'hA5; mem_din = 8'h33;
        stepCycle();
        checkOutput("wr_we_n", 32'(mem_we_n), 32'h0);
        checkOutput("wr_dout", 32'(mem_dout), 32'hA5);
        stepCycle();
        stepCycle();
        checkOutput("wr_rdata_kept", 32'(z_rdata), 32'h5A);
        idle(2);

        // Simultaneous Z80 and video requests
        z_req = 1; z_wr = 0; z_addr = 22'h000040; v_req = 1; v_addr = 22'h3F0800;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("sim_ack", 32'(v_ack), 32'h1);
        checkOutput("sim_vaddr", 32'(mem_addr), 32'h3F0800);
        stepCycle();
        stepCycle();
        checkOutput("sim_valid", 32'(v_valid), 32'h1);
        idle(2);

        // Collision: Z80 arrives on the first video cycle
        v_req = 1; v_addr = 22'h012345;
        stepCycle();
        z_req = 1; z_wr = 0; z_addr = 22'h1ABCDE;
        stepCycle();
        checkOutput("col_wait_n", 32'(z_wait_n), 32'h0);
        stepCycle();
        checkOutput("col_valid", 32'(v_valid), 32'h1);
        checkOutput("col_zaddr", 32'(mem_addr), 32'h1ABCDE);
        idle(3);

        // Abort while pending
        v_req = 1; v_addr = 22'h000777;
        stepCycle();
        z_req = 1; z_wr = 1; z_wdata = 8'hEE;
        stepCycle();
        z_req = 0;
        stepCycle();
        checkOutput("abort_ce_n", 32'(mem_ce_n), 32'h1);
        checkOutput("abort_wait_n", 32'(z_wait_n), 32'h1);
        idle(2);

        // Reset in the first video cycle
        v_req = 1; v_addr = 22'h2AAAAA;
        stepCycle();
        rst = 1;
        stepCycle();
        checkOutput("rst_ce_n", 32'(mem_ce_n), 32'h1);
        rst = 0;
        stepCycle();
        checkOutput("rst_no_valid", 32'(v_valid), 32'h0);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus();
            stepCycle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Physical memory arbiter between the Z80 and the LCD fetch engine. It sits between the blink address translation (22-bit `ma`) and the external SRAM/ROM bus, serialising accesses onto one shared memory port. The Z80 has priority. A video access already in flight is never pre-empted; a Z80 request that collides with one is held off with `z_wait_n`. Video fetches use the idle bus slots and are acknowledged and returned through a request/ack/valid handshake.

## Interface
Parameters:
- `ACC_CYC`, 2: `mck` cycles per memory access (strobe width). Legal range 1–7.

Ports:
- `mck` in 1: 9.83 MHz master clock; the only clock.
- `rst` in 1: synchronous reset, active-high.
- `z_req` in 1: Z80 memory request level (`!mrq_n`).
- `z_wr` in 1: Z80 write when 1; sampled at request start.
- `z_addr` in 22: physical address from blink.
- `z_wdata` in 8: Z80 write data.
- `z_rdata` out 8: registered Z80 read data.
- `z_wait_n` out 1: low while a Z80 request is pending (seen but not started).
- `v_req` in 1: video read request level; held with `v_addr` stable until `v_ack`.
- `v_addr` in 22: video read address.
- `v_ack` out 1: one-cycle pulse; the request has been taken.
- `v_valid` out 1: one-cycle pulse; `v_rdata` is valid.
- `v_rdata` out 8: video read data.
- `mem_addr` out 22: memory address.
- `mem_ce_n` out 1: chip enable; slot decode is done downstream from `mem_addr[21:19]`.
- `mem_oe_n` out 1: read strobe.
- `mem_we_n` out 1: write strobe.
- `mem_dout` out 8: write data.
- `mem_dq_oe` out 1: data bus drive enable.
- `mem_din` in 8: read data from memory.

## Operation
- **States:** IDLE, Z_ACC, V_ACC.
- **Down-counter:** `cnt` is 3 bits. It loads `ACC_CYC-1` on entry to an ACC state and decrements each cycle. The access ends on the edge where `cnt==0`.
- **Request edge detection:** `z_new = z_req & !z_req_d`. On `z_new`, `pend` sets and `z_wr`, `z_addr` and `z_wdata` are latched.
- **`pend` clear:**
  - `pend` clears when Z_ACC is entered.
  - `pend` also clears if `z_req` drops while pending (abort). An aborted request performs no access.
- **Grant decision:** evaluated in IDLE, and on the final cycle of any access, so accesses can run back-to-back.
  1. If `pend` or `z_new` is set, go to Z_ACC.
  2. Otherwise, if `v_req` is set, go to V_ACC and pulse `v_ack` in the first V_ACC cycle.
  3. Otherwise go to IDLE.
- **Simultaneous events:**
  - `z_new` and `v_req` in the same cycle: the Z80 wins and the video request waits.
  - `z_new` during V_ACC: the video access completes first.
- **Z_ACC read:**
  - Strobes: `mem_ce_n=0`, `mem_oe_n=0`.
  - `mem_addr` carries the latched address.
  - `z_rdata <= mem_din` on the final edge.
  - `z_rdata` holds until the next Z80 read completes.
- **Z_ACC write:**
  - Strobes: `mem_ce_n=0`, `mem_we_n=0`, `mem_dq_oe=1`.
  - `mem_dout` carries the latched data.
  - `z_rdata` is unchanged.
- **V_ACC:**
  - Read strobes as for a Z80 read.
  - On the final edge, `v_rdata <= mem_din` and `v_valid` pulses in the next cycle.
  - `v_rdata` is held until the next video access.
- **`z_wait_n`:** registered; equal to `!pend` whenever not in Z_ACC.
- **Reset values:**
  - State IDLE; `pend=0`.
  - `mem_ce_n`, `mem_oe_n`, `mem_we_n` = 1; `mem_dq_oe=0`; `mem_addr=0`; `mem_dout=0`.
  - `z_rdata=0`, `z_wait_n=1`.
  - `v_ack=0`, `v_valid=0`, `v_rdata=0`.
- **Reset mid-access:** all strobes are released on the next edge. No `v_valid` or `z_rdata` update is produced for the aborted access, and `pend` is lost.

## Timing
- **Z80 request to strobe:** `z_req` rises in cycle 0; strobes are active in cycles 1..`ACC_CYC`.
- **Z80 read data:** `z_rdata` is valid from cycle `ACC_CYC+1`.
- **Z80 wait bound:** worst-case Z80 pending time is `ACC_CYC` cycles (a collision on the first cycle of a video access). With `ACC_CYC=2`, a Z80 access fits one 3-`mck` Z80 clock.
- **Video timing:** `v_req` seen in IDLE in cycle 0 gives `v_ack` in cycle 1, strobes in cycles 1..`ACC_CYC`, and `v_valid` in cycle `ACC_CYC+1`.
- **`v_ack` timing:** the requester may drop `v_req` or change `v_addr` from the cycle after `v_ack`.
- **Back-to-back accesses:** no idle cycle is inserted between accesses. `mem_addr` and the strobes switch on the same edge.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `rst` for 2 cycles → every output at its reset value; `z_wait_n=1`, all strobes high.
- **Isolated Z80 read:** `z_req` rises in cycle 0 with `z_addr=0x080123` and memory returning 0x5A → `mem_ce_n`/`mem_oe_n` low in cycles 1–2, `mem_addr=0x080123`, `z_rdata=0x5A` from cycle 3, `z_wait_n` stays 1.
- **Z80 write:** `z_wr=1`, `z_addr=0x200010`, `z_wdata=0xA5` → `mem_we_n=0`, `mem_dq_oe=1`, `mem_dout=0xA5` in cycles 1–2; `mem_oe_n` stays 1; `z_rdata` unchanged.
- **Simultaneous requests:** `z_new` and `v_req` (`v_addr=0x3F0800`) in cycle 0 → Z80 strobes in cycles 1–2; `v_ack` in cycle 3; video strobes in cycles 3–4 at 0x3F0800; `v_valid` in cycle 5.
- **Collision:** `v_req` in cycle 0, `z_req` rises in cycle 1 → video strobes in cycles 1–2, `z_wait_n=0` in cycle 2, Z80 strobes in cycles 3–4, `v_valid` in cycle 3.
- **Abort and reset:**
  - `z_req` drops while pending → no Z80 strobes and `z_wait_n` returns to 1.
  - `rst` asserted in cycle 1 of V_ACC → strobes high in cycle 2 and no `v_valid`.
